// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// buffers words with their PCs and hands them to the core via valid/ready.
//
// state | meaning
// FETCH | normal fetching, acked words are pushed into the buffer
// DROP  | a redirect hit while a read was pending; that read is discarded on ack
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic {FETCH, DROP} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_next;
  logic                    req_next;
  logic [ADDR_WIDTH-1:0]   addr_next;

  logic [DATA_WIDTH-1:0]   buf_data [DEPTH];
  logic [ADDR_WIDTH-1:0]   buf_pc   [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count, count_after;

  logic                    acked, push, pop, flush;

  assign acked       = mem_req & mem_ack;
  assign instr_valid = (count != '0);
  assign instr       = buf_data[rd_ptr];
  assign instr_pc    = buf_pc[rd_ptr];

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = mem_req;
    addr_next     = mem_addr;
    flush         = redirect_valid;
    pop           = instr_valid & instr_ready & ~redirect_valid;
    push          = acked & ~redirect_valid & (state == FETCH);
    count_after   = count + CW'(push) - CW'(pop);

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          if (!mem_req || mem_ack) begin
            req_next  = 1'b1;
            addr_next = redirect_pc;
          end else begin
            state_next = DROP;
          end
        end else begin
          if (acked) fetch_pc_next = mem_addr + ADDR_WIDTH'(1);
          // A pending, un-acked request keeps mem_req/mem_addr as they are.
          if (!(mem_req && !mem_ack)) begin
            if (count_after < DEPTH_C) begin
              req_next  = 1'b1;
              addr_next = fetch_pc_next;
            end else begin
              req_next = 1'b0;
            end
          end
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_next = redirect_pc;
        if (acked) begin
          state_next = FETCH;
          req_next   = 1'b1;
          addr_next  = fetch_pc_next;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      mem_req  <= req_next;
      mem_addr <= addr_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count_after;
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (push) begin
      buf_data[wr_ptr] <= mem_rdata;
      buf_pc[wr_ptr]   <= mem_addr;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU decode/execute core.
- Owns the program counter and issues word reads to instruction memory over a req/ack bus (mem_addr = address bus, mem_rdata = data-in bus).
- Buffers returned words with their PCs in a small FIFO and presents them to the core with a valid/ready handshake.
- Handles branch redirects from the core, including discard of an in-flight read.

Parameters:
ADDR_WIDTH, 16, PC and memory address width (word addressed)
DATA_WIDTH, 16, instruction word width
RESET_PC, 0, PC loaded on reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  core requests PC change (taken branch/jump)
redirect_pc  in  ADDR_WIDTH  new fetch address
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_WIDTH  read address, stable while mem_req high
mem_ack  in  1  memory accepts request; mem_rdata valid this cycle
mem_rdata  in  DATA_WIDTH  read data
instr_valid  out  1  buffer head valid
instr  out  DATA_WIDTH  instruction at buffer head
instr_pc  out  ADDR_WIDTH  PC of instr
instr_ready  in  1  core consumes head this cycle

Behaviour:
- One clock, synchronous active-high reset. Reset has priority over all other inputs.
- On reset: fetch_pc=RESET_PC, FIFO empty, state=FETCH, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States: FETCH (normal), DROP (in-flight read must be discarded).
- Bus rule: mem_req and mem_addr are registered. Once mem_req rises, it and mem_addr hold until the cycle mem_ack=1. mem_ack while mem_req=0 is ignored.
- Issue rule in FETCH: mem_req=1 in the next cycle iff (count + outstanding_after_this_cycle) < DEPTH and no redirect this cycle. The FIFO can therefore never overflow.
- On ack in FETCH with no redirect:
  - Push {mem_rdata, mem_addr}.
  - fetch_pc <= mem_addr+1, wrapping modulo 2^ADDR_WIDTH.
  - mem_req may stay high with the next address, giving zero-wait throughput of 1 instruction/cycle.
- Pop: when instr_valid & instr_ready, the head is removed. Push and pop in the same cycle are both honoured; count is unchanged.
- instr/instr_pc/instr_valid are driven from the FIFO head: a push into an empty FIFO is visible the cycle after the ack.
- Redirect (redirect_valid=1), handled within the same cycle:
  - FIFO flushed; instr_valid=0 next cycle; a pop in the same cycle is ignored.
  - fetch_pc <= redirect_pc.
  - If no request is outstanding, or mem_ack=1 this cycle: any acked data is discarded, state stays FETCH, and mem_req=1 with mem_addr=redirect_pc next cycle.
  - If a request is outstanding without ack: go to DROP.
- DROP:
  - Hold mem_req/mem_addr until mem_ack, then discard the data.
  - Go to FETCH and request fetch_pc next cycle.
  - A further redirect in DROP updates fetch_pc to the latest redirect_pc and flushes again.
- Redirect latency with zero-wait memory: redirect at cycle N, mem_addr=redirect_pc at N+1, instr_valid with instr_pc=redirect_pc at N+2.
- Never produces a duplicated or skipped PC except across a redirect.
- A reset mid-transaction drops mem_req immediately at the edge; memory must tolerate an abandoned request.

Test Plan:
1. Reset release, zero-wait memory (mem_ack=mem_req, mem_rdata=addr^16'hA5A5), instr_ready=1 -> instr_pc 0,1,2,3… on consecutive cycles, instr=16'hA5A5,16'hA5A4,…; first instr_valid 2 cycles after reset deasserts.
2. Same memory, instr_ready=0 -> exactly 2 acks, then mem_req=0 and instr_pc holds 0. Set instr_ready=1 -> PCs 0,1,2… with no gap or duplicate.
3. Buffer full (PCs 4,5), redirect_valid=1, redirect_pc=16'h0040 -> instr_valid=0 next cycle, mem_addr=16'h0040 next cycle, next delivered instr_pc=16'h0040, then 16'h0041.
4. Memory acks after 3 wait cycles; redirect to 16'h0100 while the read of 16'h0007 is pending -> mem_addr stays 16'h0007 until ack, that data is never delivered, next mem_addr=16'h0100.
5. Redirect to 16'hFFFF -> delivered PCs 16'hFFFF then 16'h0000.
6. Assert reset with a request pending and 1 entry buffered -> next cycle mem_req=0, instr_valid=0; after release, fetch restarts at RESET_PC.
